binary_divider: RTL and testbench
=================================

Name: binary_divider

Overview:
- Sequential unsigned integer divider using a restoring shift-subtract algorithm, one quotient bit per clock.
- Free-running: it continuously samples `dividend` and `divisor`, computes, publishes `quotient`/`remainder`, then samples again.
- No start handshake; a one-cycle `valid` strobe marks each result update.
- Used as a leaf arithmetic block by datapaths that need a small integer divide.

Parameters:
- WIDTH, default 4, operand and result width in bits (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous assert, active-low (0 = in reset)
- dividend  input  WIDTH  unsigned numerator
- divisor  input  WIDTH  unsigned denominator
- quotient  output  WIDTH  registered result, floor(dividend/divisor)
- remainder  output  WIDTH  registered result, dividend mod divisor
- valid  output  1  one-cycle pulse when quotient/remainder update

Behaviour:
- Reset (rst=0, asynchronous):
  - quotient=0, remainder=0, valid=0.
  - Internal accumulator A=0, Q=0, M=0, count=0.
  - State=LOAD.
  - Reset is held while rst=0; release is synchronous to the next clk edge.
- States: LOAD -> ITER (WIDTH cycles) -> DONE -> LOAD. Period is WIDTH+2 cycles (6 at WIDTH=4).
- LOAD (1 cycle): A<=0, Q<=dividend, M<=divisor, count<=WIDTH; valid=0.
- ITER (one edge per bit):
  - {A,Q} shifted left by 1.
  - If shifted A >= M: A <= shifted A − M, Q[0] <= 1. Else: A <= shifted A, Q[0] <= 0.
  - count decrements; when count reaches 1 this edge, next state is DONE.
  - A needs WIDTH+1 bits internally to hold the shifted value before compare.
- DONE (1 cycle): quotient<=Q, remainder<=A (low WIDTH bits), valid<=1 for exactly this one cycle; then LOAD.
- Latency:
  - Operands are sampled on the LOAD edge.
  - The result is visible after the DONE edge, WIDTH+2 edges after the LOAD edge's cycle start.
  - Outputs hold their value between updates.
- Operand changes during ITER/DONE are ignored until the next LOAD.
- Divide by zero (M=0): the algorithm runs unmodified and yields quotient = all ones (2^WIDTH−1) and remainder = dividend. No error flag.
- dividend < divisor: quotient=0, remainder=dividend.
- All arithmetic is unsigned; no overflow is possible other than the divide-by-zero convention.
- Reset mid-operation: the computation is abandoned, outputs return to 0, and the next computation starts with LOAD after release.

Decomposition:
- Package binary_divider_pkg: state enum (LOAD, ITER, DONE), default WIDTH constant.
- Sub-module binary_divider_step: purely combinational single restoring iteration.
  - Inputs: A, Q, M.
  - Outputs: next A, next Q.
- Top instantiates one binary_divider_step plus the FSM, counter and output registers.

Test Plan:
- Reset: hold rst=0 for 3 cycles with dividend=10, divisor=10 -> quotient=0, remainder=0, valid=0 throughout. Release -> first valid pulse exactly 6 cycles later with quotient=1, remainder=0.
- Exact and inexact division: 13/3 -> quotient=4, remainder=1; 15/1 -> 15, 0; 12/4 -> 3, 0. One result per 6-cycle period, valid high exactly 1 cycle each.
- Small dividend: 3/5 -> quotient=0, remainder=3; 0/7 -> 0, 0.
- Divide by zero: 7/0 -> quotient=15, remainder=7; 0/0 -> 15, 0.
- Operand change mid-computation: dividend=9, divisor=2 sampled at LOAD, then changed to 14/3 during ITER. The first result is 4, 1; the following period yields 4, 2.
- Reset mid-operation: assert rst=0 during ITER -> outputs immediately 0, valid=0. After release, a full 6-cycle period elapses before the next valid with the correct result.

Source files
------------

// File: rtl/binary_divider_pkg.sv
// Shared definitions for the binary divider slice.
//   state_t        : divider FSM states
//   DEFAULT_WIDTH  : default operand/result width
package binary_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : binary_divider_pkg

// File: rtl/binary_divider_if.sv
// Operand/result bundle for the binary divider.
//   dividend, divisor  : unsigned operands, driven by the master
//   quotient, remainder: registered results, driven by the divider
//   valid              : one-cycle strobe when the results update
interface binary_divider_if
  import binary_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             valid;

  modport master (
    output dividend,
    output divisor,
    input  quotient,
    input  remainder,
    input  valid
  );

  modport slave (
    input  dividend,
    input  divisor,
    output quotient,
    output remainder,
    output valid
  );

endinterface : binary_divider_if

// File: rtl/binary_divider_step.sv
// One combinational restoring-division iteration.
//   a, q, m        : partial remainder, quotient/dividend shift register, divisor
//   a_next, q_next : values after shifting {a,q} left and a trial subtract
module binary_divider_step
  import binary_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next
);

  // The shifted partial remainder can exceed WIDTH bits before the compare.
  logic [WIDTH:0] a_sh;
  logic           ge;

  assign a_sh = {a, q[WIDTH-1]};
  assign ge   = (a_sh >= {1'b0, m});

  // After a successful subtract the result is below m, so it fits WIDTH bits.
  // With m == 0 the top bit is dropped here, which leaves the remainder equal
  // to the dividend once all bits have been shifted through.
  assign a_next = ge ? WIDTH'(a_sh - {1'b0, m}) : a_sh[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ge};

endmodule : binary_divider_step

// File: rtl/binary_divider.sv
// Free-running sequential unsigned divider, one quotient bit per clock.
// Samples operands in LOAD, iterates WIDTH times, publishes in DONE with a
// one-cycle valid strobe, then samples again (period WIDTH+2 cycles).
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : operand/result bundle (slave side)
//
//   state | meaning
//   LOAD  | clear A, capture dividend into Q and divisor into M
//   ITER  | one shift/trial-subtract per cycle, WIDTH cycles
//   DONE  | register quotient/remainder, pulse valid
module binary_divider
  import binary_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  binary_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             valid_r;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;

  binary_divider_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_r),
    .q      (q_r),
    .m      (m_r),
    .a_next (a_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD;
      a_r         <= '0;
      q_r         <= '0;
      m_r         <= '0;
      count       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      valid_r     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          a_r     <= '0;
          q_r     <= bus.dividend;
          m_r     <= bus.divisor;
          count   <= CW'(WIDTH);
          valid_r <= 1'b0;
          state   <= ITER;
        end
        ITER: begin
          a_r   <= a_next;
          q_r   <= q_next;
          count <= count - CW'(1);
          if (count == CW'(1)) state <= DONE;
        end
        DONE: begin
          quotient_r  <= q_r;
          remainder_r <= a_r;
          valid_r     <= 1'b1;
          state       <= LOAD;
        end
        default: begin
          valid_r <= 1'b0;
          state   <= LOAD;
        end
      endcase
    end
  end

  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.valid     = valid_r;

endmodule : binary_divider

// File: tb/tb_binary_divider.sv
// Directed bench for binary_divider at WIDTH=4. Operands are driven and
// outputs sampled on the falling edge.
module tb_binary_divider;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  binary_divider_if #(.WIDTH(W)) bus ();

  binary_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts falling edges until valid is seen (bounded at 40).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.valid && n < 40);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    bus.dividend = 4'd10;
    bus.divisor  = 4'd10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.quotient !== 4'd0 || bus.remainder !== 4'd0 || bus.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got q=%0d r=%0d v=%0b, want q=0 r=0 v=0",
                 i, bus.quotient, bus.remainder, bus.valid);
      end
    end
    rst = 1'b1;
    wait_valid(n);
    n_cmp++;
    if (n !== 6) begin
      n_bad++;
      $display("FAIL reset_release_latency: got %0d cycles, want 6", n);
    end
    n_cmp++;
    if (bus.quotient !== 4'd1 || bus.remainder !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_first_result 10/10: got q=%0d r=%0d, want q=1 r=0",
               bus.quotient, bus.remainder);
    end
  endtask

  // Called while valid is high: the next rising edge is a LOAD edge.
  task automatic test_div(input string name, input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
    int n;
    bus.dividend = dd;
    bus.divisor  = dv;
    wait_valid(n);
    n_cmp++;
    if (n !== 6) begin
      n_bad++;
      $display("FAIL %s period: got %0d cycles, want 6", name, n);
    end
    n_cmp++;
    if (bus.quotient !== eq || bus.remainder !== er) begin
      n_bad++;
      $display("FAIL %s: got q=%0d r=%0d, want q=%0d r=%0d",
               name, bus.quotient, bus.remainder, eq, er);
    end
  endtask

  task automatic test_operand_change();
    int n;
    bus.dividend = 4'd9;
    bus.divisor  = 4'd2;
    @(negedge clk);
    bus.dividend = 4'd14;
    bus.divisor  = 4'd3;
    wait_valid(n);
    n = n + 1;
    n_cmp++;
    if (n !== 6) begin
      n_bad++;
      $display("FAIL opchange period: got %0d cycles, want 6", n);
    end
    n_cmp++;
    if (bus.quotient !== 4'd4 || bus.remainder !== 4'd1) begin
      n_bad++;
      $display("FAIL opchange 9/2: got q=%0d r=%0d, want q=4 r=1",
               bus.quotient, bus.remainder);
    end
    test_div("opchange 14/3", 4'd14, 4'd3, 4'd4, 4'd2);
  endtask

  task automatic test_mid_reset();
    int n;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.quotient !== 4'd0 || bus.remainder !== 4'd0 || bus.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got q=%0d r=%0d v=%0b, want q=0 r=0 v=0",
               bus.quotient, bus.remainder, bus.valid);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.dividend = 4'd12;
    bus.divisor  = 4'd4;
    wait_valid(n);
    n_cmp++;
    if (n !== 6) begin
      n_bad++;
      $display("FAIL midreset_latency: got %0d cycles, want 6", n);
    end
    n_cmp++;
    if (bus.quotient !== 4'd3 || bus.remainder !== 4'd0) begin
      n_bad++;
      $display("FAIL midreset 12/4: got q=%0d r=%0d, want q=3 r=0",
               bus.quotient, bus.remainder);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    test_reset();
    test_div("13/3", 4'd13, 4'd3, 4'd4, 4'd1);
    test_div("15/1", 4'd15, 4'd1, 4'd15, 4'd0);
    test_div("12/4", 4'd12, 4'd4, 4'd3, 4'd0);
    test_div("3/5", 4'd3, 4'd5, 4'd0, 4'd3);
    test_div("0/7", 4'd0, 4'd7, 4'd0, 4'd0);
    test_div("7/0", 4'd7, 4'd0, 4'd15, 4'd7);
    test_div("0/0", 4'd0, 4'd0, 4'd15, 4'd0);
    test_operand_change();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_binary_divider
